// File: rtl/texto_escritor.sv
// Character writer for a text-mode display: turns a byte stream into text RAM writes
// and a moving cursor. Handles CR, LF, BS and FF (clear-screen sweep).
module texto_escritor #(
  parameter int unsigned COLS  = 64,
  parameter int unsigned ROWS  = 32,
  parameter logic [6:0]  BLANK = 7'h20
) (
  input  logic        NCLK,
  input  logic        RST,
  input  logic [6:0]  Char,
  input  logic        Valid,
  output logic        Ready,
  output logic [10:0] WrAddr,
  output logic [6:0]  WrData,
  output logic        WrEn,
  output logic [5:0]  CurCol,
  output logic [4:0]  CurRow,
  output logic        Busy
);

  localparam logic [5:0] ColMax = 6'(COLS - 1);
  localparam logic [4:0] RowMax = 5'(ROWS - 1);

  typedef enum logic [1:0] {StIdle, StWrite, StClear} state_e;

  state_e      state_q, state_d;
  logic [5:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic [6:0]  char_q, char_d;
  logic        adv_q, adv_d;
  logic [10:0] clr_q, clr_d;
  logic [4:0]  row_inc;
  logic        accept;

  assign Ready   = (state_q == StIdle) && !RST;
  assign accept  = Valid && Ready;
  assign row_inc = (row_q == RowMax) ? 5'd0 : row_q + 5'd1;
  assign CurCol  = col_q;
  assign CurRow  = row_q;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    char_d  = char_q;
    adv_d   = adv_q;
    clr_d   = clr_q;
    WrEn    = 1'b0;
    Busy    = 1'b0;
    WrAddr  = {row_q, col_q};
    WrData  = char_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (Char >= 7'h20 && Char <= 7'h7E) begin
            char_d  = Char;
            adv_d   = 1'b1;
            state_d = StWrite;
          end else begin
            case (Char)
              7'h0D: col_d = 6'd0;
              7'h0A: begin
                col_d = 6'd0;
                row_d = row_inc;
              end
              7'h08: begin
                // Step back first, then blank the cell we landed on; nothing to do at (0,0).
                if (col_q != 6'd0) begin
                  col_d   = col_q - 6'd1;
                  char_d  = BLANK;
                  adv_d   = 1'b0;
                  state_d = StWrite;
                end else if (row_q != 5'd0) begin
                  row_d   = row_q - 5'd1;
                  col_d   = ColMax;
                  char_d  = BLANK;
                  adv_d   = 1'b0;
                  state_d = StWrite;
                end
              end
              7'h0C: begin
                clr_d   = 11'd0;
                state_d = StClear;
              end
              default: ;
            endcase
          end
        end
      end
      StWrite: begin
        WrEn    = 1'b1;
        state_d = StIdle;
        if (adv_q) begin
          if (col_q == ColMax) begin
            col_d = 6'd0;
            row_d = row_inc;
          end else begin
            col_d = col_q + 6'd1;
          end
        end
      end
      StClear: begin
        // Sweep covers the whole 2K address space regardless of COLS/ROWS.
        Busy   = 1'b1;
        WrEn   = 1'b1;
        WrAddr = clr_q;
        WrData = BLANK;
        clr_d  = clr_q + 11'd1;
        if (clr_q == 11'h7FF) begin
          clr_d   = 11'd0;
          col_d   = 6'd0;
          row_d   = 5'd0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge NCLK) begin
    if (RST) begin
      state_q <= StIdle;
      col_q   <= 6'd0;
      row_q   <= 5'd0;
      char_q  <= BLANK;
      adv_q   <= 1'b0;
      clr_q   <= 11'd0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      char_q  <= char_d;
      adv_q   <= adv_d;
      clr_q   <= clr_d;
    end
  end

endmodule

// File: tb/tb_texto_escritor.sv
// Bench for texto_escritor: vector table plus hand sequences; every RAM write is
// checked against a queue of expected {addr, data} pushed when stimulus is driven.
module tb_texto_escritor;

  logic        NCLK;
  logic        RST;
  logic [6:0]  Char;
  logic        Valid;
  logic        Ready;
  logic [10:0] WrAddr;
  logic [6:0]  WrData;
  logic        WrEn;
  logic [5:0]  CurCol;
  logic [4:0]  CurRow;
  logic        Busy;

  texto_escritor dut (
    .NCLK   (NCLK),
    .RST    (RST),
    .Char   (Char),
    .Valid  (Valid),
    .Ready  (Ready),
    .WrAddr (WrAddr),
    .WrData (WrData),
    .WrEn   (WrEn),
    .CurCol (CurCol),
    .CurRow (CurRow),
    .Busy   (Busy)
  );

  initial NCLK = 1'b0;
  always #5 NCLK = ~NCLK;

  typedef struct packed {
    logic [10:0] addr;
    logic [6:0]  data;
  } wr_t;

  typedef struct {
    logic [6:0]  ch;
    logic [4:0]  exp_row;
    logic [5:0]  exp_col;
    logic        exp_wr;
    logic [10:0] exp_addr;
    logic [6:0]  exp_data;
  } vec_t;

  int  n_checks = 0;
  int  n_fail   = 0;
  int  wr_count = 0;
  wr_t exp_q[$];
  wr_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  always @(negedge NCLK) begin
    if (WrEn === 1'b1) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0h data %0h, required no write",
                 WrAddr, WrData);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(WrAddr), 32'(mon_e.addr));
        check("wr_data", 32'(WrData), 32'(mon_e.data));
      end
    end
  end

  task automatic do_reset();
    @(negedge NCLK);
    RST   = 1'b1;
    Valid = 1'b0;
    @(negedge NCLK);
    @(negedge NCLK);
    check("rst_ready", 32'(Ready), 32'd0);
    check("rst_wren",  32'(WrEn),  32'd0);
    check("rst_busy",  32'(Busy),  32'd0);
    check("rst_col",   32'(CurCol), 32'd0);
    check("rst_row",   32'(CurRow), 32'd0);
    RST = 1'b0;
    @(negedge NCLK);
    check("rst_ready_after", 32'(Ready), 32'd1);
  endtask

  // Offer a character and hold it until accepted; returns just after the accepting edge.
  task automatic send(input logic [6:0] ch);
    int n;
    n = 0;
    @(negedge NCLK);
    Char  = ch;
    Valid = 1'b1;
    while (Ready !== 1'b1 && n < 5000) begin
      @(negedge NCLK);
      n++;
    end
    if (Ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got Ready=%0b, required 1 within 5000 cycles", Ready);
      Valid = 1'b0;
      return;
    end
    @(posedge NCLK);
    #1;
    Valid = 1'b0;
  endtask

  task automatic check_cursor(input string name, input int row, input int col);
    check({name, "_row"}, 32'(CurRow), row);
    check({name, "_col"}, 32'(CurCol), col);
  endtask

  // Reset, then walk the cursor to (row,col) with LFs and spaces.
  task automatic goto_pos(input int row, input int col);
    do_reset();
    for (int r = 0; r < row; r++) send(7'h0A);
    for (int c = 0; c < col; c++) begin
      exp_q.push_back({5'(row), 6'(c), 7'h20});
      send(7'h20);
    end
    repeat (2) @(negedge NCLK);
    check_cursor("goto", row, col);
  endtask

  task automatic apply(input vec_t v);
    if (v.exp_wr) exp_q.push_back({v.exp_addr, v.exp_data});
    send(v.ch);
    @(negedge NCLK);
    check("vec_wren",   32'(WrEn),  32'(v.exp_wr));
    check("vec_ready1", 32'(Ready), 32'(!v.exp_wr));
    @(negedge NCLK);
    check("vec_ready2", 32'(Ready), 32'd1);
    check_cursor("vec", int'(v.exp_row), int'(v.exp_col));
  endtask

  vec_t vecs[12];

  initial begin
    int n;
    int w0;
    int busy_cnt;
    int ready_bad;

    vecs[0]  = '{7'h41, 5'd0, 6'd1, 1'b1, 11'h000, 7'h41};
    vecs[1]  = '{7'h08, 5'd0, 6'd0, 1'b1, 11'h000, 7'h20};
    vecs[2]  = '{7'h08, 5'd0, 6'd0, 1'b0, 11'h000, 7'h00};
    vecs[3]  = '{7'h07, 5'd0, 6'd0, 1'b0, 11'h000, 7'h00};
    vecs[4]  = '{7'h7F, 5'd0, 6'd0, 1'b0, 11'h000, 7'h00};
    vecs[5]  = '{7'h0A, 5'd1, 6'd0, 1'b0, 11'h000, 7'h00};
    vecs[6]  = '{7'h78, 5'd1, 6'd1, 1'b1, 11'h040, 7'h78};
    vecs[7]  = '{7'h0D, 5'd1, 6'd0, 1'b0, 11'h000, 7'h00};
    vecs[8]  = '{7'h7E, 5'd1, 6'd1, 1'b1, 11'h040, 7'h7E};
    vecs[9]  = '{7'h20, 5'd1, 6'd2, 1'b1, 11'h041, 7'h20};
    vecs[10] = '{7'h1F, 5'd1, 6'd2, 1'b0, 11'h000, 7'h00};
    vecs[11] = '{7'h08, 5'd1, 6'd1, 1'b1, 11'h041, 7'h20};

    RST   = 1'b1;
    Valid = 1'b0;
    Char  = 7'h00;
    repeat (2) @(negedge NCLK);
    do_reset();
    for (int i = 0; i < 12; i++) apply(vecs[i]);

    // Row-end wrap and full-screen wrap
    goto_pos(5, 63);
    apply('{7'h5A, 5'd6, 6'd0, 1'b1, 11'h17F, 7'h5A});
    goto_pos(31, 63);
    apply('{7'h5A, 5'd0, 6'd0, 1'b1, 11'h7FF, 7'h5A});

    // 'H','i',CR,LF from (2,10)
    goto_pos(2, 10);
    w0 = wr_count;
    exp_q.push_back({11'h08A, 7'h48});
    send(7'h48);
    exp_q.push_back({11'h08B, 7'h69});
    send(7'h69);
    send(7'h0D);
    repeat (2) @(negedge NCLK);
    check_cursor("cr", 2, 0);
    send(7'h0A);
    repeat (2) @(negedge NCLK);
    check_cursor("lf", 3, 0);
    check("hi_wr_count", 32'(wr_count - w0), 32'd2);

    // Backspace across a row boundary
    goto_pos(4, 0);
    apply('{7'h08, 5'd3, 6'd63, 1'b1, 11'h0FF, 7'h20});

    // Clear screen with a character held pending throughout
    goto_pos(3, 5);
    for (int a = 0; a < 2048; a++) exp_q.push_back({11'(a), 7'h20});
    exp_q.push_back({11'h000, 7'h51});
    w0 = wr_count;
    send(7'h0C);
    Char      = 7'h51;
    Valid     = 1'b1;
    busy_cnt  = 0;
    ready_bad = 0;
    n         = 0;
    while (n < 3000) begin
      @(negedge NCLK);
      n++;
      if (Busy !== 1'b1) break;
      busy_cnt++;
      if (Ready !== 1'b0) ready_bad++;
      if (busy_cnt == 1000) check_cursor("clr_mid", 3, 5);
    end
    check("clr_busy_cycles", 32'(busy_cnt), 32'd2048);
    check("clr_ready_low", 32'(ready_bad), 32'd0);
    check("clr_wr_count", 32'(wr_count - w0), 32'd2048);
    check("clr_ready_end", 32'(Ready), 32'd1);
    check_cursor("clr_end", 0, 0);
    @(posedge NCLK);
    #1;
    Valid = 1'b0;
    repeat (2) @(negedge NCLK);
    check_cursor("clr_pending", 0, 1);
    check("clr_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a sweep
    goto_pos(2, 2);
    for (int a = 0; a <= 1000; a++) exp_q.push_back({11'(a), 7'h20});
    send(7'h0C);
    n = 0;
    @(negedge NCLK);
    while (!(WrEn === 1'b1 && WrAddr == 11'd1000) && n < 1500) begin
      @(negedge NCLK);
      n++;
    end
    check("mid_reached_1000", 32'(WrAddr), 32'd1000);
    RST = 1'b1;
    @(negedge NCLK);
    check("mid_wren", 32'(WrEn), 32'd0);
    check("mid_busy", 32'(Busy), 32'd0);
    check_cursor("mid", 0, 0);
    w0  = wr_count;
    RST = 1'b0;
    repeat (5) @(negedge NCLK);
    check("mid_no_more_writes", 32'(wr_count - w0), 32'd0);
    check("mid_queue_empty", 32'(exp_q.size()), 32'd0);
    check("mid_ready", 32'(Ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/texto_escritor.md
TEXTO_ESCRITOR -- requirements
Module: texto_escritor

Interface
REQ-001 SHALL have parameter COLS, default 64, meaning text columns; the column field is 6 bits.
REQ-002 SHALL have parameter ROWS, default 32, meaning text rows; the row field is 5 bits.
REQ-003 SHALL have parameter BLANK, default 7'h20, meaning the code written by clear and backspace.
REQ-004 SHALL have port NCLK  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port Char  input  7  incoming character code.
REQ-007 SHALL have port Valid  input  1  Char is offered this cycle.
REQ-008 SHALL have port Ready  output  1  the block accepts Char this cycle.
REQ-009 SHALL have port WrAddr  output  11  text RAM address {row[4:0], col[5:0]}; this is the same layout the text renderer reads.
REQ-010 SHALL have port WrData  output  7  character code to store.
REQ-011 SHALL have port WrEn  output  1  single-cycle text RAM write strobe.
REQ-012 SHALL have port CurCol  output  6  current cursor column.
REQ-013 SHALL have port CurRow  output  5  current cursor row.
REQ-014 SHALL have port Busy  output  1  a clear-screen sweep is in progress.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, WRITE and CLEAR.
REQ-016 SHALL accept a character only on a cycle where Valid=1 and Ready=1; Ready SHALL be 1 only in IDLE.
REQ-017 SHALL keep Valid with Ready=0 pending and SHALL NOT consume it; Char is a don't-care when Valid=0.
REQ-018 SHALL handle a printable code (0x20..0x7E) as follows:
- go to WRITE;
- in the next cycle drive WrEn=1, WrAddr={CurRow,CurCol} and WrData=Char, all from a registered copy;
- advance the cursor in that same cycle;
- return to IDLE.
This gives latency 1 and throughput of one character per 2 cycles.
REQ-019 SHALL advance the cursor as follows:
- col+1;
- at col=COLS-1: col=0 and row+1;
- at row=ROWS-1 with col=COLS-1: wrap to (0,0);
- no scrolling.
REQ-020 SHALL handle CR (0x0D) by setting col=0 and leaving row unchanged, with no write, staying in IDLE.
REQ-021 SHALL handle LF (0x0A) by setting col=0 and row+1, wrapping ROWS-1 to 0, with no write.
REQ-022 SHALL handle BS (0x08) by moving the cursor back one position and then, in WRITE, writing BLANK at the new position, with the cursor not advancing afterwards:
- col>0: col-1;
- col=0 and row>0: row-1, col=COLS-1;
- at (0,0): no move and no write.
REQ-023 SHALL handle FF (0x0C) by entering CLEAR:
- Busy=1 and WrEn=1 every cycle;
- WrData=BLANK;
- WrAddr counts 0 to 2047, one address per cycle, for 2048 consecutive cycles;
- in the cycle after address 2047: Busy=0, cursor=(0,0), state returns to IDLE.
REQ-024 SHALL accept and silently discard all other codes (0x00..0x1F not listed above, and 0x7F), with no write and no cursor change.
REQ-025 SHALL drive WrEn=0 in every cycle not listed above, and WrAddr/WrData are then don't-care.
REQ-026 SHALL update CurCol and CurRow in the same cycle as the write that consumes the position.
REQ-027 SHALL keep the cursor unchanged during CLEAR until the sweep completes.

Reset
REQ-028 SHALL, while RST=1 at a rising edge, force on the next cycle:
- state=IDLE;
- CurCol=0 and CurRow=0;
- WrEn=0, Busy=0 and the clear counter at 0;
- Ready=0 while RST is high, and Ready=1 in the first cycle after RST falls.
REQ-029 SHALL let a reset during WRITE or CLEAR abort the operation immediately, with no further WrEn pulse, leaving text RAM contents partially written.
REQ-030 SHALL NOT clear text RAM contents on reset; only a received FF clears it.

Verification
REQ-031 SHALL pass the reset-then-text scenario: reset, then 'A' (0x41) at (0,0) -> WrEn one cycle after acceptance, WrAddr=0, WrData=0x41, cursor=(0,1), Ready low for exactly 1 cycle.
REQ-032 SHALL pass the end-of-row wrap scenario: cursor at (5,63), send 'Z' -> WrAddr=0x17F, then cursor=(6,0); cursor at (31,63), send 'Z' -> WrAddr=0x7FF, then cursor=(0,0).
REQ-033 SHALL pass the control-code scenario: 'H','i',CR,LF from (2,10) -> writes at 0x08A and 0x08B, then cursor (2,0), then (3,0), with exactly 2 WrEn pulses.
REQ-034 SHALL pass the backspace scenario:
- BS at (4,0) -> cursor (3,63), write 0x20 at 0x0FF;
- BS at (0,0) -> no write, cursor stays (0,0).
REQ-035 SHALL pass the clear-screen scenario:
- FF -> Busy high 2048 cycles with 2048 WrEn pulses over addresses 0..2047, all data 0x20;
- Valid held high throughout is not accepted;
- afterwards cursor=(0,0) and Ready=1.
REQ-036 SHALL pass the reset-mid-clear scenario: assert RST at address 1000 of a sweep -> next cycle WrEn=0, Busy=0, cursor=(0,0), no further writes.
